fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_buffer.sv | 74 +++++++
 rtl/fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage.
// Holds the opcode field range and ECALL opcode (also used by decode), the NOP
// encoding presented when the fetch buffer is empty, the fetch FSM state
// encodings and the PC increment.
package fetch_unit_pkg;

    // Opcode field of an instruction word.
    localparam int unsigned IR_OPCODE_MSB = 6;
    localparam int unsigned IR_OPCODE_LSB = 0;

    localparam logic [6:0]  OPCODE_ECALL  = 7'b1110011;
    localparam logic [31:0] INSTR_NOP     = 32'h0000_0013;

    localparam int unsigned PC_INC        = 4;

    // Fetch FSM state encodings.
    localparam logic [1:0]  ST_IDLE       = 2'd0;  // no request outstanding
    localparam logic [1:0]  ST_WAIT       = 2'd1;  // request outstanding
    localparam logic [1:0]  ST_HALT       = 2'd2;  // fetching stopped

    function automatic logic is_ecall(input logic [6:0] opcode);
        return opcode == OPCODE_ECALL;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {instruction, pc} between instruction memory and decode.
// Entry 0 is always the head; a pop shifts entry 1 down.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push_i           write {push_instr_i, push_pc_i} at the tail
//   pop_i            drop the head entry
//   flush_i          empty the FIFO (wins over push/pop)
//   count_o          occupancy 0..2
//   head_instr_o     instruction at the head (stale when count_o == 0)
//   head_pc_o        pc of the head instruction (stale when count_o == 0)
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [N-1:0] push_instr_i,
    input  logic [N-1:0] push_pc_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output logic [N-1:0] head_instr_o,
    output logic [N-1:0] head_pc_o
);

    logic [1:0][N-1:0] instr_q, instr_d;
    logic [1:0][N-1:0] pc_q, pc_d;
    logic [1:0]        count_q, count_d;
    logic              do_pop;
    logic              do_push;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        count_d = count_q;
        do_pop  = pop_i && (count_q != 2'd0);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push = push_i && ((count_q != 2'd2) || do_pop);
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            if (do_pop) begin
                instr_d[0] = instr_q[1];
                pc_d[0]    = pc_q[1];
                count_d    = count_d - 2'd1;
            end
            if (do_push) begin
                instr_d[count_d[0]] = push_instr_i;
                pc_d[count_d[0]]    = push_pc_i;
                count_d             = count_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= {2{N'(INSTR_NOP)}};
            pc_q    <= {2{RESET_PC}};
            count_q <= 2'd0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_instr_o = instr_q[0];
    assign head_pc_o    = pc_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the pc, keeps at most one request outstanding
// to instruction memory, buffers up to two fetched words and hands them to
// decode over a valid/ready handshake. Redirects on branch/jump resolution and
// stops fetching once an ECALL has been consumed.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect
// targets (sticky misaligned_o, fetch halted). Without it the low two target
// bits are ignored and misaligned_o is tied low.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   imem_req_o, imem_addr_o      fetch request, held with a stable address until ack
//   imem_ack_i, imem_rdata_i     request accepted, read data valid in the same cycle
//   redirect_i, redirect_pc_i    taken branch/jump pulse and its target
//   instr_valid_o, instr_ready_i decode handshake on the buffer head
//   instr_o, instr_pc_o          head instruction (NOP when empty) and its pc
//   halted_o                     ECALL consumed or misaligned trap; only redirect resumes
//   misaligned_o                 sticky misaligned-redirect flag
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req_o,
    output logic [N-1:0] imem_addr_o,
    input  logic         imem_ack_i,
    input  logic [N-1:0] imem_rdata_i,
    input  logic         redirect_i,
    input  logic [N-1:0] redirect_pc_i,
    output logic         instr_valid_o,
    input  logic         instr_ready_i,
    output logic [N-1:0] instr_o,
    output logic [N-1:0] instr_pc_o,
    output logic         halted_o,
    output logic         misaligned_o
);

    logic [1:0]   state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] addr_q, addr_d;
    logic         discard_q, discard_d;
    logic         halted_q, halted_d;

    logic         trap;
    logic [N-1:0] target_pc;
    logic         pop;
    logic         push;
    logic         ecall;
    logic         ack;
    logic         flush;
    logic         req_free;
    logic [1:0]   count_next;

    logic [1:0]   buf_count;
    logic [N-1:0] head_instr;
    logic [N-1:0] head_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q;

    assign trap      = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign target_pc = redirect_pc_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_q | trap;
        end
    end

    assign misaligned_o = misaligned_q;
`else
    logic unused_pc_low;

    assign trap          = 1'b0;
    assign target_pc     = {redirect_pc_i[N-1:2], 2'b00};
    assign unused_pc_low = ^redirect_pc_i[1:0];
    assign misaligned_o  = 1'b0;
`endif

    always_comb begin
        pop   = instr_valid_o && instr_ready_i;
        // A redirect in the same cycle wins over an ECALL being popped.
        ecall = pop && !redirect_i && is_ecall(head_instr[IR_OPCODE_MSB:IR_OPCODE_LSB]);
        ack   = (state_q == ST_WAIT) && imem_ack_i;
        flush = redirect_i || ecall;

        halted_d = halted_q;
        if (redirect_i) begin
            halted_d = trap;
        end else if (ecall) begin
            halted_d = 1'b1;
        end

        // Returned data is kept only if nothing has made it stale.
        push = ack && !discard_q && !redirect_i && !halted_d;

        if (redirect_i) begin
            pc_d = target_pc;
        end else if (push) begin
            pc_d = pc_q + N'(PC_INC);
        end else begin
            pc_d = pc_q;
        end

        count_next = flush ? 2'd0 : (buf_count + {1'b0, push} - {1'b0, pop});

        // A request made stale while outstanding is still held; its data is dropped on ack.
        discard_d = discard_q;
        if (ack) begin
            discard_d = 1'b0;
        end else if ((state_q == ST_WAIT) && flush) begin
            discard_d = 1'b1;
        end

        // Issue only when the word can land in the buffer, so it never overflows.
        req_free = (state_q != ST_WAIT) || imem_ack_i;
        state_d  = state_q;
        addr_d   = addr_q;
        if (req_free) begin
            if (!halted_d && (count_next <= 2'd1)) begin
                state_d = ST_WAIT;
                addr_d  = pc_d;
            end else if (halted_d) begin
                state_d = ST_HALT;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            discard_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
            halted_q  <= halted_d;
        end
    end

    fetch_buffer #(
        .N        (N),
        .RESET_PC (RESET_PC)
    ) u_fetch_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_instr_i (imem_rdata_i),
        .push_pc_i    (addr_q),
        .pop_i        (pop),
        .flush_i      (flush),
        .count_o      (buf_count),
        .head_instr_o (head_instr),
        .head_pc_o    (head_pc)
    );

    assign imem_req_o    = (state_q == ST_WAIT);
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = (buf_count != 2'd0);
    assign instr_o       = instr_valid_o ? head_instr : N'(INSTR_NOP);
    assign instr_pc_o    = head_pc;
    assign halted_o      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A behavioural memory answers requests
// with a programmable latency; a program-order model predicts the pc and word
// of every instruction decode consumes, plus the halted/misaligned flags.
// Directed sequences are followed by a randomized run.
module tb_fetch_unit;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        halted;
    logic        misaligned;

    fetch_unit #(
        .N        (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .halted_o      (halted),
        .misaligned_o  (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_err;
    int          consumed;

    // Outputs sampled at the falling edge of the current cycle.
    logic        obs_req, obs_valid, obs_halted, obs_mis;
    logic [31:0] obs_addr, obs_instr, obs_pc;

    // Memory model.
    int          mem_cnt;
    int          cur_lat;
    bit          lat_rand;
    logic [31:0] ecall_addr;
    bit          rand_ecall;

    // Program-order model.
    logic [31:0] exp_pc;
    bit          exp_halted;
    bit          exp_mis;
    bit          prev_red, prev_req, prev_ack;
    logic [31:0] prev_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == ecall_addr || (rand_ecall && a[7:2] == 6'd13)) begin
            return 32'h0000_0073;
        end
        return {a[26:2] ^ 25'h0ABCDEF, 7'b0010011};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        #1;
        check_eq("rst_req", imem_req, 1'b0);
        check_eq("rst_addr", imem_addr, RESET_PC);
        check_eq("rst_valid", instr_valid, 1'b0);
        check_eq("rst_instr", instr, NOP);
        check_eq("rst_instr_pc", instr_pc, RESET_PC);
        check_eq("rst_halted", halted, 1'b0);
        check_eq("rst_misaligned", misaligned, 1'b0);
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        mem_cnt    = 0;
        cur_lat    = 0;
        lat_rand   = 1'b0;
        exp_pc     = RESET_PC;
        exp_halted = 1'b0;
        exp_mis    = 1'b0;
        prev_red   = 1'b0;
        prev_req   = 1'b0;
        prev_ack   = 1'b0;
        prev_addr  = RESET_PC;
    endtask

    // One clock cycle: observe outputs, answer memory, drive decode/redirect inputs.
    task automatic step(input bit red, input logic [31:0] rpc, input bit rdy);
        logic [31:0] w;
        @(negedge clk);
        obs_req    = imem_req;
        obs_addr   = imem_addr;
        obs_valid  = instr_valid;
        obs_instr  = instr;
        obs_pc     = instr_pc;
        obs_halted = halted;
        obs_mis    = misaligned;

        check_eq("halted", obs_halted, exp_halted);
        check_eq("misaligned", obs_mis, exp_mis);
        if (!obs_valid) check_eq("nop_when_empty", obs_instr, NOP);
        if (prev_red) check_eq("valid_after_redirect", obs_valid, 1'b0);
        if (exp_halted) check_eq("valid_while_halted", obs_valid, 1'b0);
        if (prev_req && !prev_ack) begin
            check_eq("req_held", obs_req, 1'b1);
            check_eq("addr_stable", obs_addr, prev_addr);
        end else if (exp_halted) begin
            check_eq("no_req_while_halted", obs_req, 1'b0);
        end

        if (obs_req) begin
            if (mem_cnt == 0 && lat_rand) cur_lat = $urandom_range(0, 3);
            if (mem_cnt >= cur_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(obs_addr);
                mem_cnt    = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                mem_cnt++;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
        end
        redirect    = red;
        redirect_pc = red ? rpc : $urandom;
        instr_ready = rdy;

        if (obs_valid && rdy) begin
            consumed++;
            w = mem_word(exp_pc);
            check_eq("pop_pc", obs_pc, exp_pc);
            check_eq("pop_instr", obs_instr, w);
            exp_pc = exp_pc + 32'd4;
            if (!red && w[6:0] == 7'b1110011) exp_halted = 1'b1;
        end
        if (red) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            exp_pc     = rpc;
            exp_halted = (rpc[1:0] != 2'b00);
            exp_mis    = exp_mis | (rpc[1:0] != 2'b00);
`else
            exp_pc     = {rpc[31:2], 2'b00};
            exp_halted = 1'b0;
`endif
        end
        prev_red  = red;
        prev_req  = obs_req;
        prev_ack  = imem_ack;
        prev_addr = obs_addr;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          red;
        bit          rdy;
        logic [31:0] rpc;
        n_cmp      = 0;
        n_err      = 0;
        consumed   = 0;
        rst_n      = 1'b0;
        ecall_addr = 32'hFFFF_FFFF;
        rand_ecall = 1'b0;

        // Zero-wait memory, always-ready decode: one fetch per cycle.
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 32'h0, 1'b1);
            check_eq("stream_req", obs_req, 1'b1);
            check_eq("stream_addr", obs_addr, 32'(4 * (k - 1)));
            if (k >= 2) begin
                check_eq("stream_valid", obs_valid, 1'b1);
                check_eq("stream_pc", obs_pc, 32'(4 * (k - 2)));
            end
        end

        // Decode stalled: two words buffered, then drained in order.
        do_reset();
        for (int k = 1; k <= 10; k++) step(1'b0, 32'h0, 1'b0);
        check_eq("stall_req", obs_req, 1'b0);
        check_eq("stall_valid", obs_valid, 1'b1);
        check_eq("stall_head_pc", obs_pc, 32'h0);
        step(1'b0, 32'h0, 1'b1);
        check_eq("drain0_pc", obs_pc, 32'h0);
        step(1'b0, 32'h0, 1'b1);
        check_eq("drain1_pc", obs_pc, 32'h4);
        check_eq("resume_req", obs_req, 1'b1);
        check_eq("resume_addr", obs_addr, 32'h8);
        step(1'b0, 32'h0, 1'b1);
        check_eq("resume_pc", obs_pc, 32'h8);
        check_eq("resume_valid", obs_valid, 1'b1);

        // 3-cycle memory, redirect during the outstanding request.
        do_reset();
        cur_lat = 2;
        step(1'b1, 32'h100, 1'b1);
        check_eq("wait_req", obs_req, 1'b1);
        check_eq("wait_addr", obs_addr, 32'h0);
        step(1'b0, 32'h0, 1'b1);
        check_eq("held_addr", obs_addr, 32'h0);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check_eq("redir_req", obs_req, 1'b1);
        check_eq("redir_addr", obs_addr, 32'h100);
        check_eq("redir_valid", obs_valid, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check_eq("redir_first_valid", obs_valid, 1'b1);
        check_eq("redir_first_pc", obs_pc, 32'h100);

        // Redirect in the same cycle as the ack for 0x8.
        do_reset();
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h40, 1'b1);
        check_eq("ack8_addr", obs_addr, 32'h8);
        step(1'b0, 32'h0, 1'b1);
        check_eq("after_ack8_addr", obs_addr, 32'h40);
        check_eq("after_ack8_req", obs_req, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check_eq("after_ack8_pc", obs_pc, 32'h40);
        check_eq("after_ack8_valid", obs_valid, 1'b1);

        // ECALL at 0xC halts fetching until a redirect.
        do_reset();
        ecall_addr = 32'hC;
        for (int k = 1; k <= 5; k++) step(1'b0, 32'h0, 1'b1);
        check_eq("ecall_pc", obs_pc, 32'hC);
        step(1'b0, 32'h0, 1'b1);
        check_eq("ecall_halted", obs_halted, 1'b1);
        check_eq("ecall_req", obs_req, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check_eq("ecall_still_idle", obs_req, 1'b0);
        step(1'b1, 32'h200, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check_eq("resume_halted", obs_halted, 1'b0);
        check_eq("resume200_req", obs_req, 1'b1);
        check_eq("resume200_addr", obs_addr, 32'h200);
        step(1'b0, 32'h0, 1'b1);
        check_eq("resume200_pc", obs_pc, 32'h200);
        ecall_addr = 32'hFFFF_FFFF;

        // Misaligned redirect target.
        do_reset();
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h102, 1'b1);
        step(1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("mis_flag", obs_mis, 1'b1);
        check_eq("mis_halted", obs_halted, 1'b1);
        check_eq("mis_req", obs_req, 1'b0);
`else
        check_eq("mis_flag", obs_mis, 1'b0);
        check_eq("mis_req", obs_req, 1'b1);
        check_eq("mis_addr", obs_addr, 32'h100);
`endif
        step(1'b0, 32'h0, 1'b1);

        // Randomized run against the program-order model.
        do_reset();
        lat_rand   = 1'b1;
        rand_ecall = 1'b1;
        consumed   = 0;
        for (int k = 0; k < 4000; k++) begin
            red = ($urandom_range(0, 99) < 4);
            rpc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if (red && $urandom_range(0, 9) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            rdy = ($urandom_range(0, 3) != 0);
            step(red, rpc, rdy);
        end
        check_eq("random_progress", 32'(consumed > 300), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
